// File: rtl/brcomp_arbiter_if.sv
// brcomp_arbiter_if: request/response handshake bundle between requesters and the comparator arbiter
interface brcomp_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ-1:0]        req_ready_o;
   logic [N_REQ*DATA_W-1:0] req_rs1_i;
   logic [N_REQ*DATA_W-1:0] req_rs2_i;
   logic [N_REQ*3-1:0]      req_op_i;
   logic [N_REQ-1:0]        rsp_valid_o;
   logic [N_REQ-1:0]        rsp_ready_i;
   logic                    rsp_taken_o;
   logic                    rsp_err_o;
   modport master (
      output req_valid_i, req_rs1_i, req_rs2_i, req_op_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_taken_o, rsp_err_o
   );
   modport slave (
      input  req_valid_i, req_rs1_i, req_rs2_i, req_op_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_taken_o, rsp_err_o
   );
endinterface

// File: rtl/brcomp_arbiter.sv
// brcomp_arbiter: round-robin sharing of one branch comparator; BRCOMP_ARB_STATS_EN enables per-requester grant counters
module brcomp_arbiter #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   brcomp_arbiter_if.slave     bus,
   output logic [DATA_W-1:0]   cmp_rs1_o,
   output logic [DATA_W-1:0]   cmp_rs2_o,
   output logic                cmp_unsigned_o,
   input  logic                cmp_less_i,
   input  logic                cmp_equal_i,
   output logic                busy_o,
   output logic [N_REQ*32-1:0] grant_cnt_o
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] rr_q, id_q, win;
   logic [2:0]    op_q;
   logic          found, accept, taken_q, err_q, taken_c, err_c;
   // round-robin search upward from the requester after the last winner
   always_comb begin
      win   = rr_q;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!found && bus.req_valid_i[(int'(rr_q) + i) % N_REQ]) begin
            found = 1'b1;
            win   = IW'((int'(rr_q) + i) % N_REQ);
         end
      end
   end
   // next state and handshake outputs; grants only while idle
   always_comb begin
      state_d         = state_q;
      bus.req_ready_o = '0;
      bus.rsp_valid_o = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               bus.req_ready_o[win] = 1'b1;
               state_d              = CMP;
            end
         end
         CMP: state_d = RSP;
         RSP: begin
            bus.rsp_valid_o[id_q] = 1'b1;
            if (bus.rsp_ready_i[id_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign accept  = (state_q == IDLE) && found;
   assign err_c   = !op_q[2] && op_q[1];
   assign taken_c = op_q[2] ? (op_q[0] ? !cmp_less_i : cmp_less_i)
                            : (op_q[1] ? 1'b0 : (op_q[0] ? !cmp_equal_i : cmp_equal_i));
   assign cmp_unsigned_o  = op_q[1];
   assign busy_o          = state_q != IDLE;
   assign bus.rsp_taken_o = taken_q;
   assign bus.rsp_err_o   = err_q;
   // state, captured operands of the winner, and the registered result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rr_q      <= IW'(N_REQ - 1);
         id_q      <= '0;
         op_q      <= '0;
         cmp_rs1_o <= '0;
         cmp_rs2_o <= '0;
         taken_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rr_q      <= win;
            id_q      <= win;
            op_q      <= bus.req_op_i[win*3 +: 3];
            cmp_rs1_o <= bus.req_rs1_i[win*DATA_W +: DATA_W];
            cmp_rs2_o <= bus.req_rs2_i[win*DATA_W +: DATA_W];
         end
         if (state_q == CMP) begin
            taken_q <= taken_c;
            err_q   <= err_c;
         end
      end
   end
`ifdef BRCOMP_ARB_STATS_EN
   // count accepted requests per requester, wrapping at 2^32
   always_ff @(posedge clk_i) begin
      if (rst_i) grant_cnt_o <= '0;
      else if (accept) grant_cnt_o[win*32 +: 32] <= grant_cnt_o[win*32 +: 32] + 32'd1;
   end
`else
   assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_brcomp_arbiter.sv
// tb_brcomp_arbiter: directed checks of arbitration, condition decode, backpressure and reset
module tb_brcomp_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cmp_rs1, cmp_rs2;
   logic        cmp_unsigned, cmp_less, cmp_equal, busy;
   logic [63:0] grant_cnt, exp_cnt;
   int          vectors = 0;
   int          errors  = 0;
   brcomp_arbiter_if #(.N_REQ(2), .DATA_W(32)) bus ();
   brcomp_arbiter #(.N_REQ(2), .DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus),
      .cmp_rs1_o(cmp_rs1), .cmp_rs2_o(cmp_rs2), .cmp_unsigned_o(cmp_unsigned),
      .cmp_less_i(cmp_less), .cmp_equal_i(cmp_equal),
      .busy_o(busy), .grant_cnt_o(grant_cnt)
   );
   always #5 clk = ~clk;
   assign cmp_equal = cmp_rs1 == cmp_rs2;
   assign cmp_less  = cmp_unsigned ? (cmp_rs1 < cmp_rs2) : ($signed(cmp_rs1) < $signed(cmp_rs2));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid_i = v;
      bus.req_op_i    = {op, op};
      bus.req_rs1_i   = {a, a};
      bus.req_rs2_i   = {b, b};
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(2'b00, 3'b000, 32'd0, 32'd0);
      tick;
      tick;
      vectors++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", bus.req_ready_o); end
      vectors++; if (bus.rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", bus.rsp_valid_o); end
      vectors++; if ({bus.rsp_taken_o, bus.rsp_err_o, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {bus.rsp_taken_o, bus.rsp_err_o, busy}); end
      vectors++; if ({cmp_rs1, cmp_rs2, cmp_unsigned} !== 65'd0) begin errors++; $display("FAIL rst_cmp got %h want 0", {cmp_rs1, cmp_rs2, cmp_unsigned}); end
      vectors++; if (grant_cnt !== 64'd0) begin errors++; $display("FAIL rst_cnt got %h want 0", grant_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_blt;
      drive(2'b01, 3'b100, 32'hFFFF_FFFB, 32'd3);
      #1;
      vectors++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL blt_ready got %b want 01", bus.req_ready_o); end
      tick;
      bus.req_valid_i = 2'b00;
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL blt_busy got %b want 1", busy); end
      vectors++; if (cmp_unsigned !== 1'b0) begin errors++; $display("FAIL blt_unsigned got %b want 0", cmp_unsigned); end
      vectors++; if (cmp_rs1 !== 32'hFFFF_FFFB) begin errors++; $display("FAIL blt_rs1 got %h want fffffffb", cmp_rs1); end
      vectors++; if (bus.rsp_valid_o !== 2'b00) begin errors++; $display("FAIL blt_early_rsp got %b want 00", bus.rsp_valid_o); end
      tick;
      vectors++; if (bus.rsp_valid_o !== 2'b01) begin errors++; $display("FAIL blt_rsp_valid got %b want 01", bus.rsp_valid_o); end
      vectors++; if ({bus.rsp_taken_o, bus.rsp_err_o} !== 2'b10) begin errors++; $display("FAIL blt_result got %b want 10", {bus.rsp_taken_o, bus.rsp_err_o}); end
      tick;
      vectors++; if ({busy, bus.rsp_valid_o} !== 3'b000) begin errors++; $display("FAIL blt_idle got %b want 000", {busy, bus.rsp_valid_o}); end
   endtask

   task automatic test_bltu;
      drive(2'b01, 3'b110, 32'hFFFF_FFFB, 32'd3);
      #1;
      vectors++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL bltu_ready got %b want 01", bus.req_ready_o); end
      tick;
      bus.req_valid_i = 2'b00;
      vectors++; if (cmp_unsigned !== 1'b1) begin errors++; $display("FAIL bltu_unsigned got %b want 1", cmp_unsigned); end
      tick;
      vectors++; if (bus.rsp_valid_o !== 2'b01) begin errors++; $display("FAIL bltu_rsp_valid got %b want 01", bus.rsp_valid_o); end
      vectors++; if ({bus.rsp_taken_o, bus.rsp_err_o} !== 2'b00) begin errors++; $display("FAIL bltu_result got %b want 00", {bus.rsp_taken_o, bus.rsp_err_o}); end
      tick;
   endtask

   task automatic test_alternate;
      logic [1:0] exp;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      drive(2'b11, 3'b000, 32'h8000_0000, 32'h8000_0000);
      #1;
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2 == 1) ? 2'b10 : 2'b01;
         vectors++; if (bus.req_ready_o !== exp) begin errors++; $display("FAIL alt_grant%0d got %b want %b", k, bus.req_ready_o, exp); end
         tick;
         vectors++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL alt_cmp_ready%0d got %b want 00", k, bus.req_ready_o); end
         tick;
         vectors++; if (bus.rsp_valid_o !== exp) begin errors++; $display("FAIL alt_rsp%0d got %b want %b", k, bus.rsp_valid_o, exp); end
         vectors++; if (bus.rsp_taken_o !== 1'b1) begin errors++; $display("FAIL alt_taken%0d got %b want 1", k, bus.rsp_taken_o); end
         tick;
      end
      bus.req_valid_i = 2'b00;
`ifdef BRCOMP_ARB_STATS_EN
      exp_cnt = {32'd2, 32'd2};
`else
      exp_cnt = 64'd0;
`endif
      vectors++; if (grant_cnt !== exp_cnt) begin errors++; $display("FAIL alt_cnt got %h want %h", grant_cnt, exp_cnt); end
   endtask

   task automatic test_backpressure;
      bus.rsp_ready_i = 2'b00;
      drive(2'b10, 3'b101, 32'd5, 32'd5);
      #1;
      vectors++; if (bus.req_ready_o !== 2'b10) begin errors++; $display("FAIL bp_ready got %b want 10", bus.req_ready_o); end
      tick;
      bus.req_valid_i = 2'b01;
      #1;
      vectors++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL bp_cmp_ready got %b want 00", bus.req_ready_o); end
      tick;
      for (int i = 0; i < 3; i++) begin
         bus.rsp_ready_i = 2'b01;
         #1;
         vectors++; if (bus.rsp_valid_o !== 2'b10) begin errors++; $display("FAIL bp_hold%0d got %b want 10", i, bus.rsp_valid_o); end
         vectors++; if (bus.rsp_taken_o !== 1'b1) begin errors++; $display("FAIL bp_taken%0d got %b want 1", i, bus.rsp_taken_o); end
         vectors++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b want 00", i, bus.req_ready_o); end
         tick;
      end
      bus.rsp_ready_i = 2'b10;
      #1;
      vectors++; if (bus.rsp_valid_o !== 2'b10) begin errors++; $display("FAIL bp_last got %b want 10", bus.rsp_valid_o); end
      tick;
      vectors++; if ({busy, bus.rsp_valid_o} !== 3'b000) begin errors++; $display("FAIL bp_idle got %b want 000", {busy, bus.rsp_valid_o}); end
      bus.req_valid_i = 2'b00;
      bus.rsp_ready_i = 2'b11;
   endtask

   task automatic test_illegal;
      drive(2'b01, 3'b010, 32'd7, 32'd9);
      #1;
      vectors++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL ill_ready got %b want 01", bus.req_ready_o); end
      tick;
      bus.req_valid_i = 2'b00;
      tick;
      vectors++; if ({bus.rsp_valid_o, bus.rsp_taken_o, bus.rsp_err_o} !== 4'b0101) begin errors++; $display("FAIL ill_result got %b want 0101", {bus.rsp_valid_o, bus.rsp_taken_o, bus.rsp_err_o}); end
      tick;
      drive(2'b01, 3'b001, 32'd1, 32'd2);
      tick;
      bus.req_valid_i = 2'b00;
      tick;
      vectors++; if ({bus.rsp_valid_o, bus.rsp_taken_o, bus.rsp_err_o} !== 4'b0110) begin errors++; $display("FAIL legal_result got %b want 0110", {bus.rsp_valid_o, bus.rsp_taken_o, bus.rsp_err_o}); end
      tick;
   endtask

   task automatic test_reset_mid;
      drive(2'b10, 3'b000, 32'd3, 32'd3);
      tick;
      bus.req_valid_i = 2'b00;
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_cmp_busy got %b want 1", busy); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      vectors++; if ({busy, bus.rsp_valid_o, bus.rsp_taken_o} !== 4'b0000) begin errors++; $display("FAIL rm_flush got %b want 0000", {busy, bus.rsp_valid_o, bus.rsp_taken_o}); end
      vectors++; if (grant_cnt !== 64'd0) begin errors++; $display("FAIL rm_cnt_clr got %h want 0", grant_cnt); end
      drive(2'b11, 3'b100, 32'd1, 32'd2);
      #1;
      vectors++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL rm_grant got %b want 01", bus.req_ready_o); end
      tick;
      bus.req_valid_i = 2'b00;
      tick;
      vectors++; if ({bus.rsp_valid_o, bus.rsp_taken_o, bus.rsp_err_o} !== 4'b0110) begin errors++; $display("FAIL rm_result got %b want 0110", {bus.rsp_valid_o, bus.rsp_taken_o, bus.rsp_err_o}); end
      tick;
`ifdef BRCOMP_ARB_STATS_EN
      exp_cnt = {32'd0, 32'd1};
`else
      exp_cnt = 64'd0;
`endif
      vectors++; if (grant_cnt !== exp_cnt) begin errors++; $display("FAIL rm_cnt got %h want %h", grant_cnt, exp_cnt); end
   endtask

   initial begin
      bus.rsp_ready_i = 2'b11;
      drive(2'b00, 3'b000, 32'd0, 32'd0);
      test_reset;
      test_blt;
      test_bltu;
      test_alternate;
      test_backpressure;
      test_illegal;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
